// File: rtl/load_store_unit.sv
// RV32I memory-access stage: alignment/region checks, registered-read bus
// sequencing, load extension and read-modify-write for byte/half stores.
module load_store_unit #(
    parameter int RAM_SELECT_BIT = 10,
    parameter int RAM_TOP_BIT    = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_fault,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        MERGE_WRITE,
        WRITE_WAIT,
        RESPOND
    } state_t;

    state_t      state_q, state_d;
    logic        rd_phase_q, rd_phase_d;
    logic        op_write_q, op_write_d;
    logic [2:0]  op_funct3_q, op_funct3_d;
    logic [1:0]  op_lane_q, op_lane_d;
    logic [31:0] op_wdata_q, op_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [1:0]  resp_fault_q, resp_fault_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_read_write_q, mem_read_write_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;

    // Range is checked before alignment, alignment before ROM protection.
    function automatic logic [1:0] classify(input logic [31:0] addr, input logic [2:0] f3,
                                            input logic wr);
        logic [1:0] f;
        f = 2'b00;
        if (addr[31:RAM_TOP_BIT+2] != '0)
            f = 2'b11;
        else if ((f3[1:0] == 2'b01 && addr[0]) || (f3[1] && addr[1:0] != 2'b00))
            f = 2'b01;
        else if (wr && !addr[RAM_SELECT_BIT])
            f = 2'b10;
        return f;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {lane, 3'b000};
        b = shifted[7:0];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] data;
        if (f3[1:0] == 2'b00) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            data = {24'b0, wd[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            data = {16'b0, wd[15:0]} << {lane[1], 4'b0000};
        end
        return (old & ~mask) | (data & mask);
    endfunction

    always_comb begin
        state_d          = state_q;
        rd_phase_d       = rd_phase_q;
        op_write_d       = op_write_q;
        op_funct3_d      = op_funct3_q;
        op_lane_d        = op_lane_q;
        op_wdata_d       = op_wdata_q;
        resp_valid_d     = 1'b0;
        resp_data_d      = resp_data_q;
        resp_fault_d     = resp_fault_q;
        mem_address_d    = mem_address_q;
        mem_read_write_d = 1'b0;
        mem_write_data_d = mem_write_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_write_d    = req_write;
                    op_funct3_d   = req_funct3;
                    op_lane_d     = req_address[1:0];
                    op_wdata_d    = req_write_data;
                    resp_data_d   = 32'b0;
                    resp_fault_d  = classify(req_address, req_funct3, req_write);
                    if (resp_fault_d != 2'b00) begin
                        state_d = RESPOND;
                    end else if (req_write && req_funct3[1]) begin
                        mem_address_d    = {req_address[31:2], 2'b00};
                        mem_read_write_d = 1'b1;
                        mem_write_data_d = req_write_data;
                        state_d          = WRITE_WAIT;
                    end else begin
                        mem_address_d = {req_address[31:2], 2'b00};
                        rd_phase_d    = 1'b0;
                        state_d       = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                // First cycle: memory samples the address; second: data is on the bus.
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else if (op_write_q) begin
                    mem_write_data_d = merge_store(mem_read_data, op_wdata_q, op_funct3_q, op_lane_q);
                    mem_read_write_d = 1'b1;
                    state_d          = MERGE_WRITE;
                end else begin
                    resp_data_d  = extend_load(mem_read_data, op_funct3_q, op_lane_q);
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            WRITE_WAIT: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            MERGE_WRITE: begin
                resp_valid_d = 1'b1;
                state_d      = RESPOND;
            end
            RESPOND: begin
                // Faults pulse on the way out; merged stores already pulsed on the way in.
                resp_valid_d = ~resp_valid_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            rd_phase_q       <= 1'b0;
            op_write_q       <= 1'b0;
            op_funct3_q      <= 3'b0;
            op_lane_q        <= 2'b0;
            op_wdata_q       <= 32'b0;
            resp_valid_q     <= 1'b0;
            resp_data_q      <= 32'b0;
            resp_fault_q     <= 2'b0;
            mem_address_q    <= 32'b0;
            mem_read_write_q <= 1'b0;
            mem_write_data_q <= 32'b0;
        end else begin
            state_q          <= state_d;
            rd_phase_q       <= rd_phase_d;
            op_write_q       <= op_write_d;
            op_funct3_q      <= op_funct3_d;
            op_lane_q        <= op_lane_d;
            op_wdata_q       <= op_wdata_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            resp_fault_q     <= resp_fault_d;
            mem_address_q    <= mem_address_d;
            mem_read_write_q <= mem_read_write_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign busy           = ~req_ready;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_fault     = resp_fault_q;
    assign mem_address    = mem_address_q;
    assign mem_read_write = mem_read_write_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a registered-read memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_fault;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_address(req_address), .req_write_data(req_write_data),
        .busy(busy), .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_read_write(mem_read_write),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:511];
    always @(posedge clk) begin
        if (mem_read_write) mem[mem_address[10:2]] <= mem_write_data;
        mem_read_data <= mem[mem_address[10:2]];
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  fault;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   accepts = 0;
    int   wr_cnt = 0;
    int   busy_cnt = 0;
    int   last_acc = 0;
    int   prev_acc = 0;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (req_valid && req_ready && !reset) begin
            accepts++;
            acc_q.push_back(cyc);
            prev_acc = last_acc;
            last_acc = cyc;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (mem_read_write) wr_cnt++;
        if (busy) busy_cnt++;
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
                chk($sformatf("data@%h", e.addr), resp_data, e.data);
                chk($sformatf("fault@%h", e.addr), {30'b0, resp_fault}, {30'b0, e.fault});
                chk($sformatf("latency@%h", e.addr), cyc - a, e.lat);
            end
        end
    end

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] fault, input int lat);
        exp_t e;
        e.addr = addr; e.data = data; e.fault = fault; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(sb.size() == 0 && req_ready) && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 30) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_data,
                         input logic [1:0] exp_fault, input int lat, input int writes);
        int w0;
        w0 = wr_cnt;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3;
        req_address = addr; req_write_data = wd;
        push_exp(addr, exp_data, exp_fault, lat);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_done();
        chk($sformatf("writes@%h", addr), wr_cnt - w0, writes);
    endtask

    initial begin
        int w0, b0, a0, n;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[4] = 32'hCAFE_F00D;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
        req_address = 32'h0; req_write_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_fault", {30'b0, resp_fault}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_rw", {31'b0, mem_read_write}, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        reset = 1'b0;
        @(negedge clk); #1;

        do_op(1, F_W,  32'h400, 32'hDEAD_BEEF, 32'h0,         2'b00, 1, 1);
        do_op(0, F_W,  32'h400, 32'h0,         32'hDEAD_BEEF, 2'b00, 2, 0);
        do_op(1, F_W,  32'h404, 32'h1122_3344, 32'h0,         2'b00, 1, 1);
        do_op(1, F_B,  32'h405, 32'h1234_56AA, 32'h0,         2'b00, 3, 1);
        do_op(0, F_W,  32'h404, 32'h0,         32'h1122_AA44, 2'b00, 2, 0);
        do_op(0, F_B,  32'h405, 32'h0,         32'hFFFF_FFAA, 2'b00, 2, 0);
        do_op(0, F_BU, 32'h405, 32'h0,         32'h0000_00AA, 2'b00, 2, 0);
        do_op(1, F_H,  32'h406, 32'h5555_8001, 32'h0,         2'b00, 3, 1);
        do_op(0, F_H,  32'h406, 32'h0,         32'hFFFF_8001, 2'b00, 2, 0);
        do_op(0, F_HU, 32'h406, 32'h0,         32'h0000_8001, 2'b00, 2, 0);
        do_op(0, F_W,  32'h404, 32'h0,         32'h8001_AA44, 2'b00, 2, 0);
        do_op(0, F_W,  32'h010, 32'h0,         32'hCAFE_F00D, 2'b00, 2, 0);
        do_op(0, F_B,  32'h013, 32'h0,         32'hFFFF_FFCA, 2'b00, 2, 0);
        do_op(0, F_HU, 32'h012, 32'h0,         32'h0000_CAFE, 2'b00, 2, 0);
        do_op(0, F_W,  32'h402, 32'h0,         32'h0,         2'b01, 1, 0);
        do_op(0, F_H,  32'h401, 32'h0,         32'h0,         2'b01, 1, 0);
        do_op(1, F_W,  32'h010, 32'h1,         32'h0,         2'b10, 1, 0);
        do_op(0, F_W,  32'h800, 32'h0,         32'h0,         2'b11, 1, 0);
        do_op(1, F_W,  32'h802, 32'h1,         32'h0,         2'b11, 1, 0);
        do_op(1, F_H,  32'h011, 32'h1,         32'h0,         2'b01, 1, 0);

        // SB with req_valid held high the whole time.
        w0 = wr_cnt; b0 = busy_cnt; a0 = accepts;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F_B;
        req_address = 32'h408; req_write_data = 32'h0000_0077;
        push_exp(32'h408, 32'h0, 2'b00, 3);
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        wait_done();
        chk("hold_accepts", accepts - a0, 1);
        chk("hold_busy_cycles", busy_cnt - b0, 4);
        chk("hold_writes", wr_cnt - w0, 1);
        do_op(0, F_W, 32'h408, 32'h0, 32'h0000_0077, 2'b00, 2, 0);

        // Back-to-back loads with req_valid held.
        a0 = accepts;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = F_W; req_address = 32'h400;
        push_exp(32'h400, 32'hDEAD_BEEF, 2'b00, 2);
        @(posedge clk); #1;
        req_address = 32'h404;
        push_exp(32'h404, 32'h8001_AA44, 2'b00, 2);
        n = 0;
        while (accepts - a0 < 2 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        req_valid = 1'b0;
        wait_done();
        chk("b2b_accepts", accepts - a0, 2);
        chk("b2b_spacing", last_acc - prev_acc, 3);

        // Reset while an SB sits in READ_WAIT.
        w0 = wr_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = F_B;
        req_address = 32'h40C; req_write_data = 32'h0000_00EE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        acc_q.delete();
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        repeat (6) @(negedge clk);
        #1;
        chk("rst_mid_writes", wr_cnt - w0, 0);
        do_op(0, F_W, 32'h40C, 32'h0, 32'h0, 2'b00, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
